// File: rtl/bitty_pkg.sv
// Shared bitty definitions: fetch FSM states, instruction format fields, branch conditions.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package bitty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  // Format field lives in instr[1:0]; 2'b10 marks a branch handled by fetch itself.
  localparam logic [1:0] FMT_BRANCH = 2'b10;

  // Branch condition codes in instr[3:2], compared against the core result register.
  typedef enum logic [1:0] {
    COND_ZERO  = 2'd0,
    COND_ONE   = 2'd1,
    COND_TWO   = 2'd2,
    COND_NEVER = 2'd3
  } br_cond_t;

  function automatic logic branch_taken(input logic [1:0] cond, input logic [15:0] d_out);
    logic taken;
    taken = 1'b0;
    case (br_cond_t'(cond))
      COND_ZERO: taken = (d_out == 16'd0);
      COND_ONE:  taken = (d_out == 16'd1);
      COND_TWO:  taken = (d_out == 16'd2);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Cycle counter bounding how long fetch waits for the core's done pulse.
// Latency: expired asserts combinationally in the TIMEOUT-th enabled cycle after clr.
// Backpressure: none; counts every enabled cycle and holds once expired.
// Ports: clk/reset (async active-low), clr restarts the count, en counts one cycle,
//        expired flags that the current enabled cycle is the last one allowed.
module fetch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of enabled cycles already completed, so the
  // TIMEOUT-th cycle is the one that sees TIMEOUT-1.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction fetch/sequencer for the bitty core: fetches, resolves branches, issues run.
// Latency: non-branch 3 cycles + core time, branch 2 cycles, halt word 2 cycles to HALT.
// Backpressure: waits for core done (bounded by TIMEOUT); start ignored while busy.
// Ports: clk, reset (async active-low), start; mem_addr/mem_rdata external instruction
//        memory (1-cycle read); d_instr/run/done/d_out core handshake; pc, halted, error status.
module bitty_fetch
  import bitty_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       d_instr,
  output logic              run,
  input  logic              done,
  input  logic [15:0]       d_out,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       d_instr_q, d_instr_d;
  logic              error_q, error_d;

  logic              is_halt, is_branch, br_taken;
  logic [ADDR_W-1:0] br_target, pc_inc;
  logic              wd_expired;

  // Decode fields are only meaningful in DECODE, when mem_rdata holds the word at pc.
  assign is_halt   = (mem_rdata == HALT_WORD);
  assign is_branch = (mem_rdata[1:0] == FMT_BRANCH);
  assign br_taken  = branch_taken(mem_rdata[3:2], d_out);
  assign br_target = ADDR_W'(mem_rdata >> 4);
  assign pc_inc    = pc_q + ADDR_W'(1);  // wraps at 2^ADDR_W by width

  fetch_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_EXEC),
    .en     (state_q == ST_WAIT_DONE),
    .expired(wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_halt)        state_d = ST_HALT;
        else if (is_branch) state_d = ST_FETCH;
        else                state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // done wins over a timeout landing in the same cycle
        if (done)            state_d = ST_FETCH;
        else if (wd_expired) state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    run      = (state_q == ST_EXEC);
    halted   = (state_q == ST_HALT);
    mem_addr = pc_q;
  end

  // Datapath next values; d_instr only changes in DECODE so it is stable for the core.
  always_comb begin
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) pc_d = '0;
      end
      ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      ST_DECODE: begin
        d_instr_d = mem_rdata;
        if (!is_halt && is_branch) begin
          pc_d = br_taken ? br_target : pc_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (done)            pc_d    = pc_inc;
        else if (wd_expired) error_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      d_instr_q <= '0;
      error_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      error_q   <= error_d;
    end
  end

  assign pc      = pc_q;
  assign d_instr = d_instr_q;
  assign error   = error_q;

endmodule
